// File: rtl/keccak_block_padder.sv
// Sponge absorb framing: packs 32-bit words into rate-sized blocks, pads the final word and closes the block.
// Define SHAKE_DOMAIN_EN to use the SHAKE domain byte 0x1F instead of the SHA3 byte 0x06.
module keccak_block_padder #(
  parameter int RATE_WORDS = 34
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               in,
  input  logic                      in_ready,
  input  logic                      is_last,
  input  logic [1:0]                byte_num,
  output logic                      buffer_full,
  output logic [32*RATE_WORDS-1:0]  out,
  output logic                      out_ready,
  output logic                      block_last,
  input  logic                      f_ack
);

  localparam int RATE_BITS = 32 * RATE_WORDS;
  localparam int CW = $clog2(RATE_WORDS + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(RATE_WORDS - 1);

`ifdef SHAKE_DOMAIN_EN
  localparam logic [7:0] DOMAIN = 8'h1F;
`else
  localparam logic [7:0] DOMAIN = 8'h06;
`endif

  localparam logic [1:0] ABSORB   = 2'd0;
  localparam logic [1:0] PAD_FILL = 2'd1;
  localparam logic [1:0] FULL     = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          accept;
  logic          shift_en;
  logic          padding;
  logic [31:0]   pad_word;
  logic [31:0]   shift_word;

  assign buffer_full = (state != ABSORB);

  always_comb begin
    pad_word = {DOMAIN, 24'h0};
    case (byte_num)
      2'd1:    pad_word = {in[31:24], DOMAIN, 16'h0};
      2'd2:    pad_word = {in[31:16], DOMAIN, 8'h0};
      2'd3:    pad_word = {in[31:8], DOMAIN};
      default: pad_word = {DOMAIN, 24'h0};
    endcase
  end

  // The closing rate bit is only added while padding; a plain data word landing in the last slot is untouched.
  always_comb begin
    accept   = in_ready && (state == ABSORB);
    shift_en = accept || (state == PAD_FILL);
    padding  = (accept && is_last) || (state == PAD_FILL);
    if (state == PAD_FILL)
      shift_word = 32'h0;
    else if (is_last)
      shift_word = pad_word;
    else
      shift_word = in;
    if (padding && (count == LAST_SLOT))
      shift_word = shift_word | 32'h0000_0080;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ABSORB;
      count      <= '0;
      out        <= '0;
      out_ready  <= 1'b0;
      block_last <= 1'b0;
    end else begin
      if (shift_en) begin
        out   <= {out[RATE_BITS-33:0], shift_word};
        count <= count + CW'(1);
      end
      case (state)
        ABSORB: begin
          if (accept) begin
            if (count == LAST_SLOT) begin
              state      <= FULL;
              out_ready  <= 1'b1;
              block_last <= is_last;
            end else if (is_last) begin
              state <= PAD_FILL;
            end
          end
        end
        PAD_FILL: begin
          if (count == LAST_SLOT) begin
            state      <= FULL;
            out_ready  <= 1'b1;
            block_last <= 1'b1;
          end
        end
        FULL: begin
          if (f_ack) begin
            count     <= '0;
            out_ready <= 1'b0;
            state     <= block_last ? DONE : ABSORB;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_block_padder.sv
// Self-checking bench for keccak_block_padder: vector table on a 4-word rate instance plus
// hand sequences for hold, back-to-back blocks, ignored input, resets and the default 34-word rate.
module tb_keccak_block_padder;

`ifdef SHAKE_DOMAIN_EN
  localparam logic [7:0] DB = 8'h1F;
`else
  localparam logic [7:0] DB = 8'h06;
`endif
  localparam logic [7:0] DL = DB | 8'h80;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [31:0]  in = '0;
  logic         in_ready = 1'b0;
  logic         is_last = 1'b0;
  logic [1:0]   byte_num = '0;
  logic         f_ack = 1'b0;
  logic         buffer_full;
  logic [127:0] out;
  logic         out_ready;
  logic         block_last;

  logic          reset34 = 1'b1;
  logic [31:0]   in34 = '0;
  logic          in_ready34 = 1'b0;
  logic          is_last34 = 1'b0;
  logic [1:0]    byte_num34 = '0;
  logic          f_ack34 = 1'b0;
  logic          buffer_full34;
  logic [1087:0] out34;
  logic          out_ready34;
  logic          block_last34;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [127:0] blk;
    logic         last;
  } exp_t;
  exp_t sb[$];
  exp_t mon_exp;
  logic seen = 1'b0;

  typedef struct {
    int                nw;
    logic [3:0][31:0]  w;
    logic [1:0]        bn;
    logic [31:0]       lw;
    logic [127:0]      exp;
    int                fill;
  } vec_t;
  vec_t vecs[6];

  keccak_block_padder #(.RATE_WORDS(4)) dut (
    .clk(clk), .reset(reset), .in(in), .in_ready(in_ready), .is_last(is_last),
    .byte_num(byte_num), .buffer_full(buffer_full), .out(out), .out_ready(out_ready),
    .block_last(block_last), .f_ack(f_ack)
  );

  keccak_block_padder dut34 (
    .clk(clk), .reset(reset34), .in(in34), .in_ready(in_ready34), .is_last(is_last34),
    .byte_num(byte_num34), .buffer_full(buffer_full34), .out(out34), .out_ready(out_ready34),
    .block_last(block_last34), .f_ack(f_ack34)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Each rising out_ready consumes one scoreboard entry.
  always @(negedge clk) begin
    if (out_ready && !seen) begin
      seen = 1'b1;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected block: got %h want none", out);
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("block data", out, mon_exp.blk);
        checkOutput("block last", {127'h0, block_last}, {127'h0, mon_exp.last});
      end
    end else if (!out_ready) begin
      seen = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    in_ready = 1'b0;
    f_ack = 1'b0;
    is_last = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] word, input logic last, input logic [1:0] bn);
    in = word;
    is_last = last;
    byte_num = bn;
    in_ready = 1'b1;
    step();
    in_ready = 1'b0;
    is_last = 1'b0;
  endtask

  task automatic waitReady(input int fill, input string name);
    int waited = 0;
    while (!out_ready && waited < 50) begin
      step();
      waited++;
    end
    checkOutput(name, 128'(waited), 128'(fill));
  endtask

  task automatic doAck();
    f_ack = 1'b1;
    step();
    f_ack = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1, {32'h0, 32'h0, 32'h0, 32'h11223344}, 2'd1, 32'hAA55AA55,
                {32'h11223344, 8'hAA, DB, 16'h0, 32'h0, 32'h80}, 2};
    vecs[1] = '{3, {32'h0, 32'h03030303, 32'h02020202, 32'h01010101}, 2'd3, 32'hDDEEFF99,
                {32'h01010101, 32'h02020202, 32'h03030303, 24'hDDEEFF, DL}, 0};
    vecs[2] = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 2'd0, 32'hFFFFFFFF,
                {DB, 24'h0, 64'h0, 32'h80}, 3};
    vecs[3] = '{2, {32'h0, 32'h0, 32'h5E6F7081, 32'hA1B2C3D4}, 2'd2, 32'h12345678,
                {32'hA1B2C3D4, 32'h5E6F7081, 16'h1234, DB, 8'h00, 32'h80}, 1};
    vecs[4] = '{0, {32'h0, 32'h0, 32'h0, 32'h0}, 2'd3, 32'hCAFEBABE,
                {24'hCAFEBA, DB, 64'h0, 32'h80}, 3};
    vecs[5] = '{2, {32'h0, 32'h0, 32'hF0F0F0F0, 32'h0F0F0F0F}, 2'd0, 32'h55555555,
                {32'h0F0F0F0F, 32'hF0F0F0F0, DB, 24'h0, 32'h80}, 1};

    resetDut();
    checkOutput("reset out", out, 128'h0);
    checkOutput("reset out_ready", {127'h0, out_ready}, 128'h0);
    checkOutput("reset block_last", {127'h0, block_last}, 128'h0);
    checkOutput("reset buffer_full", {127'h0, buffer_full}, 128'h0);

    for (int v = 0; v < 6; v++) begin
      resetDut();
      for (int i = 0; i < vecs[v].nw; i++)
        applyStimulus(vecs[v].w[i], 1'b0, 2'd0);
      sb.push_back('{vecs[v].exp, 1'b1});
      applyStimulus(vecs[v].lw, 1'b1, vecs[v].bn);
      waitReady(vecs[v].fill, "vec fill cycles");
      doAck();
      checkOutput("vec done full", {127'h0, buffer_full}, 128'h1);
      checkOutput("vec done ready", {127'h0, out_ready}, 128'h0);
    end

    // Completed block must hold while the consumer stalls.
    resetDut();
    sb.push_back('{{32'h11223344, 8'hAA, DB, 16'h0, 32'h0, 32'h80}, 1'b1});
    applyStimulus(32'h11223344, 1'b0, 2'd0);
    applyStimulus(32'hAA55AA55, 1'b1, 2'd1);
    waitReady(2, "hold fill cycles");
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("hold out", out, {32'h11223344, 8'hAA, DB, 16'h0, 32'h0, 32'h80});
      checkOutput("hold ready", {127'h0, out_ready}, 128'h1);
      checkOutput("hold full", {127'h0, buffer_full}, 128'h1);
    end
    doAck();

    // Full non-final block, then an empty final word forms a second block.
    resetDut();
    sb.push_back('{{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004}, 1'b0});
    for (int i = 1; i <= 4; i++)
      applyStimulus(32'hA0000000 + 32'(i), 1'b0, 2'd0);
    waitReady(0, "b1 latency");
    doAck();
    checkOutput("b1 ack full", {127'h0, buffer_full}, 128'h0);
    checkOutput("b1 ack ready", {127'h0, out_ready}, 128'h0);
    sb.push_back('{{DB, 24'h0, 64'h0, 32'h80}, 1'b1});
    applyStimulus(32'h12345678, 1'b1, 2'd0);
    waitReady(3, "b2 fill cycles");
    doAck();
    in_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("done full", {127'h0, buffer_full}, 128'h1);
      checkOutput("done ready", {127'h0, out_ready}, 128'h0);
      step();
    end
    in_ready = 1'b0;

    // in_ready held high throughout, including FULL and f_ack cycles.
    resetDut();
    sb.push_back('{{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003}, 1'b0});
    sb.push_back('{{32'hC0DE0007, 32'hC0DE0008, 32'hC0DE0009, 32'hC0DE000A}, 1'b0});
    for (int c = 0; c < 12; c++) begin
      in_ready = 1'b1;
      is_last = 1'b0;
      in = 32'hC0DE0000 + 32'(c);
      f_ack = (c == 6 || c == 11);
      checkOutput("stream full", {127'h0, buffer_full},
                  {127'h0, ((c >= 4 && c <= 6) || c == 11)});
      step();
    end
    in_ready = 1'b0;
    f_ack = 1'b0;
    checkOutput("stream end full", {127'h0, buffer_full}, 128'h0);

    // Reset during PAD_FILL.
    resetDut();
    applyStimulus(32'h77665544, 1'b1, 2'd1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst fill out", out, 128'h0);
    checkOutput("rst fill ready", {127'h0, out_ready}, 128'h0);
    checkOutput("rst fill full", {127'h0, buffer_full}, 128'h0);
    sb.push_back('{{32'h44444444, 16'h9999, DB, 8'h00, 32'h0, 32'h80}, 1'b1});
    applyStimulus(32'h44444444, 1'b0, 2'd0);
    applyStimulus(32'h9999ABCD, 1'b1, 2'd2);
    waitReady(2, "rst fill restart");
    doAck();

    // Reset during FULL.
    resetDut();
    sb.push_back('{{32'hB1B1B1B1, 32'hB2B2B2B2, 32'hB3B3B3B3, 32'hB4B4B4B4}, 1'b0});
    applyStimulus(32'hB1B1B1B1, 1'b0, 2'd0);
    applyStimulus(32'hB2B2B2B2, 1'b0, 2'd0);
    applyStimulus(32'hB3B3B3B3, 1'b0, 2'd0);
    applyStimulus(32'hB4B4B4B4, 1'b0, 2'd0);
    waitReady(0, "rst full latency");
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("rst full out", out, 128'h0);
    checkOutput("rst full ready", {127'h0, out_ready}, 128'h0);
    checkOutput("rst full full", {127'h0, buffer_full}, 128'h0);
    sb.push_back('{{24'h010203, DB, 64'h0, 32'h80}, 1'b1});
    applyStimulus(32'h010203FF, 1'b1, 2'd3);
    waitReady(3, "rst full restart");
    doAck();

    // Default 34-word rate: lone partial word as the whole message.
    begin
      int waited = 0;
      step();
      reset34 = 1'b0;
      checkOutput("r34 reset full", {127'h0, buffer_full34}, 128'h0);
      in34 = 32'hCAFE0000;
      is_last34 = 1'b1;
      byte_num34 = 2'd2;
      in_ready34 = 1'b1;
      step();
      in_ready34 = 1'b0;
      is_last34 = 1'b0;
      while (!out_ready34 && waited < 100) begin
        step();
        waited++;
      end
      checkOutput("r34 fill cycles", 128'(waited), 128'd33);
      checkOutput("r34 first word", {96'h0, out34[1087:1056]}, {96'h0, 16'hCAFE, DB, 8'h00});
      checkOutput("r34 last word", {96'h0, out34[31:0]}, 128'h80);
      checkOutput("r34 middle zero", {127'h0, |out34[1055:32]}, 128'h0);
      checkOutput("r34 block_last", {127'h0, block_last34}, 128'h1);
      f_ack34 = 1'b1;
      step();
      f_ack34 = 1'b0;
      checkOutput("r34 done full", {127'h0, buffer_full34}, 128'h1);
    end

    step();
    checkOutput("scoreboard drained", 128'(sb.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keccak_block_padder.md
Name: keccak_block_padder

Overview:
- Absorb-side framing stage of the SHA3/SHAKE sponge: accepts 32-bit message words plus last-word byte count and emits full rate-sized blocks to the permutation core.
- Applies the partial-word padding rule, fills the rest of the block with zeros, and sets the final rate bit (0x80 in the lowest byte of the block's last word).
- Sits directly downstream of the word-level pad function and upstream of the Keccak-f permutation wrapper, with a block-level ready/ack handshake.

Parameters:
- RATE_WORDS, 34, rate in 32-bit words (34 = SHA3-256 1088 bits; 42 = SHAKE128 1344 bits); legal range ≥2
- RATE_BITS, 32*RATE_WORDS, derived localparam; width of out

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in  in  32  message word, first byte in [31:24]
- in_ready  in  1  in/is_last/byte_num valid this cycle
- is_last  in  1  current word is the final (partial) word
- byte_num  in  2  valid bytes in final word (0..3), meaningful only with is_last
- buffer_full  out  1  stage cannot accept a word this cycle
- out  out  RATE_BITS  assembled block, first word in [RATE_BITS-1 -: 32]
- out_ready  out  1  block in out is complete and stable
- block_last  out  1  qualifies out_ready: this is the message's final block
- f_ack  in  1  consumer has taken the block

Behaviour:
- Reset is synchronous and active-high: out=0, out_ready=0, block_last=0, buffer_full=0, count=0, state=ABSORB.
- Storage is a shift register. An accepted word does out <= {out[RATE_BITS-33:0], word} and count+1. The word is visible in out the cycle after acceptance.
- Word accepted iff in_ready && !buffer_full. in_ready while buffer_full is ignored; no state change.
- Pad word for is_last, with D = domain byte (0x06 by default). Data bytes are kept MSB-first; byte slot byte_num gets D; lower slots get 0x00.
  - byte_num=0 -> {D,24'h0}, in ignored
  - byte_num=1 -> {in[31:24],D,16'h0}
  - byte_num=2 -> {in[31:16],D,8'h0}
  - byte_num=3 -> {in[31:8],D}
- If a shifted word lands in slot RATE_WORDS-1 while padding (the pad word itself or a fill word), its [7:0] is OR'd with 0x80. The pad word occupying the last slot gives a low byte of D|0x80 (0x86 default).
- Padding always completes in the current block: a last word always has ≥1 free byte, so no extra padding-only block is ever generated.
- States:
  - ABSORB: accepts words. Non-last word: shift; on count reaching RATE_WORDS go FULL (block_last=0). Last word: shift pad word; if count now == RATE_WORDS go FULL (block_last=1), else PAD_FILL.
  - PAD_FILL: shift one zero word per cycle (0x00000080 for the final slot). When count == RATE_WORDS go FULL with block_last=1.
  - FULL: out_ready=1; out, block_last held stable. On f_ack: count=0, out_ready=0. Then go ABSORB if block_last=0, else DONE.
  - DONE: all inputs ignored, buffer_full=1, out_ready=0, until reset.
- buffer_full = (state != ABSORB). It is a registered-state decode; no combinational path from in_ready.
- f_ack outside FULL is ignored. In the f_ack cycle, in_ready is ignored because buffer_full=1.
- Reset mid-block or mid-fill discards all progress; next message starts at word 0.
- out in ABSORB is partial and undefined for consumers; only valid with out_ready=1.

Optional Feature:
- SHAKE_DOMAIN_EN
  - Defined: domain byte D=0x1F (SHAKE XOF). The last-slot combined byte becomes 0x9F.
  - Undefined: D=0x06 (SHA3 hash). All other behaviour is identical.

Test Plan:
- RATE_WORDS=4.
  - Stimulus: 0x11223344 (not last), then is_last byte_num=1 in=0xAA55AA55.
  - Required: 2 fill cycles, then out_ready=1, block_last=1, out=0x11223344_AA060000_00000000_00000080. Hold out_ready 5 cycles without f_ack -> out stable, buffer_full=1.
- RATE_WORDS=4.
  - Stimulus: 3 words 0x01010101, 0x02020202, 0x03030303, then is_last byte_num=3 in=0xDDEEFF99.
  - Required: out_ready the next cycle, no PAD_FILL, last word 0xDDEEFF86. With SHAKE_DOMAIN_EN, 0xDDEEFF9F.
- RATE_WORDS=4.
  - Stimulus: 4 full words, no is_last.
  - Required: out_ready=1, block_last=0. f_ack -> ABSORB. Then is_last byte_num=0 -> second block 0x06000000_00000000_00000000_00000080, block_last=1. After its f_ack, buffer_full stays 1 (DONE).
- Stimulus: in_ready asserted every cycle, including while buffer_full and during the f_ack cycle.
  - Required: only words in non-full cycles are captured; the count of captured words equals the number of ABSORB cycles.
- Stimulus: reset asserted during PAD_FILL and during FULL.
  - Required: next cycle out=0, out_ready=0, buffer_full=0. A new message then produces a correct block from word 0.
- RATE_WORDS=34 default.
  - Stimulus: is_last byte_num=2 in=0xCAFE0000 as the first word.
  - Required: 33 fill cycles, out[1087:1056]=0xCAFE0600, out[31:0]=0x00000080, all else 0.
